// File: rtl/bus_select_ctrl.sv
// Multicycle control FSM for the simple RISC processor.
// Decodes IR into one-hot bus selects, register loads and A/G/IR strobes.
module bus_select_ctrl #(
  parameter logic [2:0] OP_MV  = 3'b000,
  parameter logic [2:0] OP_MVI = 3'b001,
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_SUB = 3'b011
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       run,
  input  logic [8:0] ir,
  output logic [7:0] reg_sel,
  output logic       g_out,
  output logic       din_out,
  output logic [7:0] reg_in,
  output logic       ir_in,
  output logic       a_in,
  output logic       g_in,
  output logic       addsub,
  output logic       done,
  output logic [1:0] tstep
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [2:0] op;
  logic [7:0] x_oh;
  logic [7:0] y_oh;
  logic       is_mv;
  logic       is_mvi;
  logic       is_alu;

  assign op     = ir[8:6];
  assign x_oh   = 8'b1 << ir[5:3];
  assign y_oh   = 8'b1 << ir[2:0];
  assign is_mv  = (op == OP_MV);
  assign is_mvi = (op == OP_MVI);
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);
  assign tstep  = state;

  always_ff @(posedge clock) begin
    if (!resetn) state <= T0;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      T0: state_nx = run ? T1 : T0;
      T1: state_nx = is_alu ? T2 : T0;
      T2: state_nx = T3;
      T3: state_nx = T0;
      default: state_nx = T0;
    endcase
  end

  // Illegal opcodes fall through every T1 branch and only raise done.
  always_comb begin
    reg_sel = '0;
    g_out   = 1'b0;
    din_out = 1'b0;
    reg_in  = '0;
    ir_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    case (state)
      T0: ir_in = 1'b1;
      T1: begin
        unique case (1'b1)
          is_mv: begin
            reg_sel = y_oh;
            reg_in  = x_oh;
            done    = 1'b1;
          end
          is_mvi: begin
            din_out = 1'b1;
            reg_in  = x_oh;
            done    = 1'b1;
          end
          is_alu: begin
            reg_sel = x_oh;
            a_in    = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        reg_sel = y_oh;
        g_in    = 1'b1;
        addsub  = (op == OP_SUB);
      end
      T3: begin
        g_out  = 1'b1;
        reg_in = x_oh;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/bus_select_ctrl.md
Name: bus_select_ctrl

Overview:
- Multicycle control FSM of the simple RISC processor.
- Decodes the 9-bit instruction register (fields III XXX YYY) into the one-hot bus-source selects that drive the 8-way one-hot bus mux, the one-hot register load enables, and the A/G/IR load strobes.
- Sits between the IR and the datapath. It is the producer end of the one-hot select interface that the bus mux consumes.

Parameters:
- OP_MV, 3'b000, opcode for mv Rx,Ry
- OP_MVI, 3'b001, opcode for mvi Rx,#D (immediate taken from din)
- OP_ADD, 3'b010, opcode for add Rx,Ry
- OP_SUB, 3'b011, opcode for sub Rx,Ry

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- resetn  input  1  synchronous, active-low reset
- run  input  1  start strobe; sampled only in state T0
- ir  input  9  IR contents: ir[8:6]=opcode, ir[5:3]=X, ir[2:0]=Y
- reg_sel  output  8  one-hot register bus-out select (R7..R0) to the bus mux
- g_out  output  1  drive G onto the bus
- din_out  output  1  drive din onto the bus
- reg_in  output  8  one-hot register load enables (R7..R0)
- ir_in  output  1  IR load enable
- a_in  output  1  A register load enable
- g_in  output  1  G register load enable
- addsub  output  1  ALU op: 0=add, 1=subtract
- done  output  1  instruction complete pulse
- tstep  output  2  current step (0..3), for debug

Behaviour:
- States: T0 (2'd0), T1, T2, T3. The state register is updated only on the rising clock edge.
- All outputs are combinational decodes of state and ir. Every output not listed for a state is 0.
- Reset: when resetn=0 at a clock edge, state becomes T0 regardless of state or run. This holds mid-instruction: the instruction is abandoned, and no reg_in or done is asserted in the cycle after the reset edge.
- While in T0 (including during reset), outputs are: ir_in=1, tstep=0, all else 0.
- T0:
  - ir_in=1.
  - If run=1 → T1; else stay in T0.
  - run is ignored in T1–T3.
- T1, mv:
  - reg_sel=onehot(Y), reg_in=onehot(X), done=1.
  - → T0.
- T1, mvi:
  - din_out=1, reg_in=onehot(X), done=1.
  - → T0.
- T1, add/sub:
  - reg_sel=onehot(X), a_in=1.
  - → T2.
- T1, any other opcode (illegal):
  - done=1; no bus drive, no loads.
  - → T0.
- T2 (add/sub):
  - reg_sel=onehot(Y), g_in=1, addsub=(opcode==OP_SUB).
  - → T3.
- T3 (add/sub):
  - g_out=1, reg_in=onehot(X), done=1.
  - → T0.
- Latency, counting from the cycle run is sampled in T0:
  - mv, mvi, illegal: done in the next cycle (2 cycles total).
  - add, sub: done 3 cycles later (4 cycles total).
- Invariant: at most one of {reg_sel bits, g_out, din_out} is 1 in any cycle. reg_sel is either all-zero or exactly one-hot.
- Invariant: reg_in is either all-zero or exactly one-hot.
- Same-register operands (X==Y) are legal:
  - mv R3,R3 gives reg_sel=reg_in=8'h08.
  - add R3,R3 uses R3 for both operands.
- ir is not latched internally. The surrounding datapath holds IR stable from T1 through T3; ir_in=0 in T1–T3 guarantees this.
- run held high continuously: the FSM returns to T0 and starts the next instruction on the following edge, so back-to-back instructions are separated by exactly one T0 cycle.
- Unreachable encodings do not exist, since all 4 states are used.

Test Plan:
- Reset:
  - Hold resetn=0 for 2 cycles.
  - Then tstep=0, ir_in=1, reg_sel=0, reg_in=0, done=0.
- mv R5,R2:
  - Apply ir=9'b000_101_010, run=1 for 1 cycle.
  - Next cycle: reg_sel=8'h04, reg_in=8'h20, done=1.
  - Following cycle: tstep=0.
- mvi R0:
  - Apply ir=9'b001_000_xxx, run pulse.
  - T1: din_out=1, reg_in=8'h01, done=1, reg_sel=0.
- sub R1,R7:
  - Apply ir=9'b011_001_111.
  - T1: reg_sel=8'h02, a_in=1.
  - T2: reg_sel=8'h80, g_in=1, addsub=1.
  - T3: g_out=1, reg_in=8'h02, done=1.
  - 4 cycles total.
- Illegal opcode:
  - Apply ir=9'b110_011_001.
  - T1: done=1, all selects and enables 0.
  - Then back in T0.
- Reset mid-op:
  - Start add R2,R4.
  - Deassert resetn at the T2 edge.
  - Next cycle: tstep=0, reg_in=0, done=0.
  - With run held low, the FSM stays in T0.
